// File: rtl/merge_core_if.sv
// rtl/merge_core_if.sv - handshake bundle between merge_core and its upstream/downstream FIFOs
interface merge_core_if;
    logic [31:0] i_fifo_1;
    logic        i_fifo_1_empty;
    logic [31:0] i_fifo_2;
    logic        i_fifo_2_empty;
    logic        i_fifo_out_ready;
    logic        o_fifo_1_read;
    logic        o_fifo_2_read;
    logic        o_out_fifo_write;
    logic [31:0] o_data;

    modport slave (
        input  i_fifo_1, i_fifo_1_empty, i_fifo_2, i_fifo_2_empty, i_fifo_out_ready,
        output o_fifo_1_read, o_fifo_2_read, o_out_fifo_write, o_data
    );

    modport master (
        output i_fifo_1, i_fifo_1_empty, i_fifo_2, i_fifo_2_empty, i_fifo_out_ready,
        input  o_fifo_1_read, o_fifo_2_read, o_out_fifo_write, o_data
    );
endinterface

// File: rtl/merge_core.sv
// rtl/merge_core.sv - two-way merge of non-increasing zero-terminated key runs
module merge_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [31:0] i_din,
    input  logic        i_pop,
    output logic [31:0] o_head,
    output logic        o_empty,
    output logic        o_full
);
    localparam logic [AW:0] L_FULL = DEPTH[AW:0];

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == L_FULL);
endmodule

module merge_core #(
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    merge_core_if.slave  bus
);
    logic [31:0] w_head_a, w_head_b, w_head_c, w_din_c;
    logic        w_empty_a, w_empty_b, w_empty_c;
    logic        w_full_a, w_full_b, w_full_c;
    logic        w_pop_a, w_pop_b, w_pop_c, w_push_c;
    logic        w_read_1, w_read_2, w_merge_en;

    assign w_pop_c    = ~i_rst & ~w_empty_c & bus.i_fifo_out_ready;
    assign w_merge_en = ~i_rst & ~w_empty_a & ~w_empty_b & (~w_full_c | w_pop_c);

    // A double-zero collapses both terminators into one; ties go to stream A.
    always_comb begin
        w_pop_a  = 1'b0;
        w_pop_b  = 1'b0;
        w_push_c = 1'b0;
        w_din_c  = '0;
        if (w_merge_en) begin
            w_push_c = 1'b1;
            if (w_head_a == '0 && w_head_b == '0) begin
                w_pop_a = 1'b1;
                w_pop_b = 1'b1;
            end else if (w_head_a == '0) begin
                w_din_c = w_head_b;
                w_pop_b = 1'b1;
            end else if (w_head_b == '0 || w_head_a >= w_head_b) begin
                w_din_c = w_head_a;
                w_pop_a = 1'b1;
            end else begin
                w_din_c = w_head_b;
                w_pop_b = 1'b1;
            end
        end
    end

    assign w_read_1 = ~i_rst & ~bus.i_fifo_1_empty & (~w_full_a | w_pop_a);
    assign w_read_2 = ~i_rst & ~bus.i_fifo_2_empty & (~w_full_b | w_pop_b);

    merge_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_read_1), .i_din(bus.i_fifo_1),
        .i_pop(w_pop_a), .o_head(w_head_a), .o_empty(w_empty_a), .o_full(w_full_a)
    );

    merge_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_read_2), .i_din(bus.i_fifo_2),
        .i_pop(w_pop_b), .o_head(w_head_b), .o_empty(w_empty_b), .o_full(w_full_b)
    );

    merge_fifo #(.DEPTH(DEPTH)) u_fifo_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_push_c), .i_din(w_din_c),
        .i_pop(w_pop_c), .o_head(w_head_c), .o_empty(w_empty_c), .o_full(w_full_c)
    );

    assign bus.o_fifo_1_read    = w_read_1;
    assign bus.o_fifo_2_read    = w_read_2;
    assign bus.o_out_fifo_write = w_pop_c;
    // An empty C may point at a stale slot, so its head is masked.
    assign bus.o_data           = (i_rst | w_empty_c) ? 32'd0 : w_head_c;
endmodule

// File: tb/tb_merge_core.sv
// tb/tb_merge_core.sv - directed self-checking bench for merge_core
module tb_merge_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    merge_core_if bus();

    merge_core #(.DEPTH(4)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] got[$];
    int          got_cyc[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cyc = -1;
    logic        last_r1, last_r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_up();
        bus.i_fifo_1       = (q1.size() > 0) ? q1[0] : 32'd0;
        bus.i_fifo_1_empty = (q1.size() == 0);
        bus.i_fifo_2       = (q2.size() > 0) ? q2[0] : 32'd0;
        bus.i_fifo_2_empty = (q2.size() == 0);
    endtask

    task automatic tick();
        logic r1, r2;
        @(negedge clk);
        r1 = bus.o_fifo_1_read;
        r2 = bus.o_fifo_2_read;
        last_r1 = r1;
        last_r2 = r2;
        if ((r1 || r2) && rd_cyc < 0) rd_cyc = cyc;
        if (bus.o_out_fifo_write) begin
            got.push_back(bus.o_data);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r1 && q1.size() > 0) void'(q1.pop_front());
        if (r2 && q2.size() > 0) void'(q2.pop_front());
        drive_up();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q1.delete();
        q2.delete();
        got.delete();
        got_cyc.delete();
        rd_cyc = -1;
        drive_up();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_seq(input string tag);
        logic [31:0] obs;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
            chk($sformatf("%s_%0d", tag, i), obs, exp_q[i]);
        end
    endtask

    initial begin
        int zeros;
        bus.i_fifo_out_ready = 1'b1;
        q1.delete();
        q2.delete();
        drive_up();

        // Reset held with both streams non-empty, then basic merge
        start_reset();
        q1 = '{32'd9, 32'd5, 32'd2, 32'd0};
        q2 = '{32'd8, 32'd5, 32'd1, 32'd0};
        drive_up();
        @(negedge clk);
        chk("rst_read1", bus.o_fifo_1_read, 32'd0);
        chk("rst_read2", bus.o_fifo_2_read, 32'd0);
        chk("rst_write", bus.o_out_fifo_write, 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        release_reset();
        tick();
        chk("first_read1", last_r1, 32'd1);
        chk("first_read2", last_r2, 32'd1);
        run(20);
        exp_q = '{32'd9, 32'd8, 32'd5, 32'd5, 32'd2, 32'd1, 32'd0};
        check_seq("basic");
        zeros = 0;
        foreach (got[i]) if (got[i] == 32'd0) zeros++;
        chk("basic_zero_count", zeros, 32'd1);

        // Latency from idle
        start_reset();
        q1 = '{32'd7};
        q2 = '{32'd0};
        drive_up();
        release_reset();
        run(8);
        chk("lat_count", got.size(), 32'd1);
        chk("lat_data", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, 32'd7);
        chk("lat_cycles", (got_cyc.size() > 0) ? got_cyc[0] - rd_cyc : -1, 32'd2);

        // Backpressure: downstream held off for 20 cycles
        start_reset();
        for (int k = 20; k >= 2; k -= 2) q1.push_back(k);
        q1.push_back(32'd0);
        for (int k = 19; k >= 1; k -= 2) q2.push_back(k);
        q2.push_back(32'd0);
        bus.i_fifo_out_ready = 1'b0;
        drive_up();
        release_reset();
        run(20);
        chk("bp_no_write", got.size(), 32'd0);
        chk("bp_read1_low", last_r1, 32'd0);
        chk("bp_read2_low", last_r2, 32'd0);
        chk("bp_cnt_a", dut.u_fifo_a.r_count, 32'd4);
        chk("bp_cnt_b", dut.u_fifo_b.r_count, 32'd4);
        chk("bp_cnt_c", dut.u_fifo_c.r_count, 32'd4);
        chk("bp_left1", q1.size(), 32'd5);
        chk("bp_left2", q2.size(), 32'd5);
        bus.i_fifo_out_ready = 1'b1;
        run(40);
        exp_q.delete();
        for (int k = 20; k >= 1; k--) exp_q.push_back(k);
        exp_q.push_back(32'd0);
        check_seq("bp");

        // Starvation: stream 2 empty
        start_reset();
        q1 = '{32'd6, 32'd4, 32'd0};
        drive_up();
        release_reset();
        run(10);
        chk("starve_no_out", got.size(), 32'd0);
        chk("starve_q1_drained", q1.size(), 32'd0);
        q2 = '{32'd5, 32'd0};
        drive_up();
        run(10);
        exp_q = '{32'd6, 32'd5, 32'd4, 32'd0};
        check_seq("starve");

        // Mid-stream reset after three outputs
        start_reset();
        q1 = '{32'd9, 32'd5, 32'd2, 32'd0};
        q2 = '{32'd8, 32'd5, 32'd1, 32'd0};
        drive_up();
        release_reset();
        for (int i = 0; i < 50 && got.size() < 3; i++) tick();
        chk("mid_three_out", got.size(), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_read1", bus.o_fifo_1_read, 32'd0);
        chk("mid_rst_read2", bus.o_fifo_2_read, 32'd0);
        chk("mid_rst_write", bus.o_out_fifo_write, 32'd0);
        chk("mid_rst_data", bus.o_data, 32'd0);
        start_reset();
        q1 = '{32'd3, 32'd0};
        q2 = '{32'd2, 32'd0};
        drive_up();
        release_reset();
        run(12);
        exp_q = '{32'd3, 32'd2, 32'd0};
        check_seq("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
